// File: rtl/peak_frame_collect.sv
// peak_frame_collect: accumulates FRAME_LEN 4-bit peak bins into one frame and hands out sum, average, min/max and frame ID
// ports: clk, rst (sync active-high) | frame_start pulse opens a frame
//        pk_valid/pk_ready/pk_data: upstream peak handshake
//        avg_valid/avg_ready: result handshake for sum_data, avg_data, min_data, max_data, frame_id
//        busy: high while collecting or presenting
// PEAK_FRAME_MINMAX_EN: compiles in min/max tracking; otherwise min_data/max_data are tied to 0
module peak_frame_collect #(
  parameter int FRAME_LEN  = 16,
  parameter int LOG2_FRAME = 4,
  parameter int SUM_DW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pk_valid,
  input  logic [3:0]        pk_data,
  output logic              pk_ready,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [SUM_DW-1:0] sum_data,
  output logic [3:0]        avg_data,
  output logic [3:0]        min_data,
  output logic [3:0]        max_data,
  output logic [7:0]        frame_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;
  localparam logic [LOG2_FRAME:0] LAST = (LOG2_FRAME+1)'(FRAME_LEN-1);
  state_t state, state_nx;
  logic [SUM_DW-1:0] sum_q;
  logic [LOG2_FRAME:0] cnt_q;
  logic [7:0] id_q;
  logic pend_q, pk_hs, av_hs, last_pk, clr;
  assign pk_ready  = state == COLLECT;
  assign avg_valid = state == OUTPUT;
  assign busy      = state != IDLE;
  assign pk_hs     = pk_valid & pk_ready;
  assign av_hs     = avg_valid & avg_ready;
  // a restart in the same cycle wins over the frame-completing peak
  assign last_pk   = pk_hs & ~frame_start & (cnt_q == LAST);
  always_comb begin
    state_nx = state == IDLE    ? (frame_start ? COLLECT : IDLE) :
               state == COLLECT ? (last_pk ? OUTPUT : COLLECT) :
               av_hs            ? ((pend_q | frame_start) ? COLLECT : IDLE) : OUTPUT;
    clr = (state_nx == COLLECT) & ((state != COLLECT) | frame_start);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      if (clr) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (pk_hs) begin
        sum_q <= sum_q + SUM_DW'(pk_data);
        cnt_q <= cnt_q + 1'b1;
      end
      if (av_hs) id_q <= id_q + 8'd1;
      // a start seen while presenting is remembered until COLLECT is entered
      pend_q <= (state_nx != COLLECT) & (pend_q | ((state == OUTPUT) & frame_start));
    end
  end
  assign sum_data = sum_q;
  assign avg_data = sum_q[LOG2_FRAME +: 4];
  assign frame_id = id_q;
`ifdef PEAK_FRAME_MINMAX_EN
  logic [3:0] min_q, max_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= 4'h0;
      max_q <= 4'h0;
    end else if (clr) begin
      min_q <= 4'hF;
      max_q <= 4'h0;
    end else if (pk_hs) begin
      min_q <= pk_data < min_q ? pk_data : min_q;
      max_q <= pk_data > max_q ? pk_data : max_q;
    end
  end
  assign min_data = min_q;
  assign max_data = max_q;
`else
  assign min_data = 4'h0;
  assign max_data = 4'h0;
`endif
endmodule
